pc_fetch_unit: RTL and testbench
================================

PC_FETCH_UNIT -- requirements
Module: pc_fetch_unit

Interface
REQ-001 SHALL have parameter: RESET_PC, 16'h0000, PC value loaded on reset.
REQ-002 SHALL have ports: clk  input  1  single clock, all state rising-edge.
REQ-003 SHALL have ports: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have ports: new_pc  input  16  next PC from next-PC logic, computed from if_pc.
REQ-005 SHALL have ports: halt  input  1  decoded halt for the instruction currently on if_instr.
REQ-006 SHALL have ports: id_stall  input  1  decode cannot accept if_instr this cycle.
REQ-007 SHALL have ports: imem_rdy  input  1  instruction memory returns imem_data this cycle.
REQ-008 SHALL have ports: imem_data  input  16  instruction word.
REQ-009 SHALL have ports: imem_req  output  1  fetch request.
REQ-010 SHALL have ports: imem_addr  output  16  fetch address.
REQ-011 SHALL have ports: if_valid  output  1  if_instr/if_pc hold a fetched instruction.
REQ-012 SHALL have ports: if_instr  output  16  registered instruction.
REQ-013 SHALL have ports: if_pc  output  16  address of if_instr; feeds next-PC logic.
REQ-014 SHALL have ports: halted  output  1  unit stopped by halt.
REQ-015 SHALL have ports: fetch_cnt, stall_cnt  output  16 each  performance counters.

Function
REQ-016 SHALL implement states FETCH, VALID, HALTED; all outputs registered or decoded from state only.
REQ-017 FETCH: imem_req=1, imem_addr=pc_q; on imem_rdy capture imem_data->if_instr, pc_q->if_pc, go VALID next edge; no imem_rdy: stay FETCH, hold request and address.
REQ-018 VALID: if_valid=1, imem_req=0; if_instr and if_pc SHALL stay stable while id_stall=1.
REQ-019 VALID with id_stall=0 and halt=0: pc_q<=new_pc, go FETCH; fetch_cnt increments.
REQ-020 VALID with id_stall=0 and halt=1: pc_q<=new_pc, go HALTED; fetch_cnt increments.
REQ-021 VALID with id_stall=1: halt and new_pc ignored; stall_cnt increments each such cycle.
REQ-022 HALTED: imem_req=0, if_valid=0, halted=1; exit only by reset.
REQ-023 imem_rdy outside FETCH SHALL be ignored; minimum latency req->if_valid is 1 cycle (2 cycles per instruction).
REQ-024 new_pc loaded unmodified; wrap-around (16'hFFFF -> 16'h0000) is the upstream logic's result, never corrected here.
REQ-025 Counters SHALL saturate at 16'hFFFF, never wrap.

Reset
REQ-026 rst_n low SHALL immediately force state=FETCH, pc_q=RESET_PC, if_instr=0, if_pc=0, if_valid=0, halted=0, counters=0.
REQ-027 Reset mid-fetch SHALL abandon the pending request; first cycle after release issues imem_addr=RESET_PC.

Configuration
REQ-028 Macro FETCH_PERF_CNT_EN defined: fetch_cnt/stall_cnt behave per REQ-019..REQ-025.
REQ-029 Macro absent: counter logic removed, ports remain, driven constant 0.

Structure
REQ-030 Shared package fetch_pkg SHALL hold state enum typedef, WORD_W=16, default RESET_PC.
REQ-031 One sub-module sat_counter (16-bit, enable, saturating, async active-low clear) SHALL be instantiated twice, only under FETCH_PERF_CNT_EN.

Verification
REQ-032 Reset release, imem_rdy=1 always, new_pc=if_pc+1 -> addresses 0,1,2 fetched; if_valid every second cycle; fetch_cnt=3 after third accept.
REQ-033 imem_rdy withheld 3 cycles at pc=5 -> imem_req/imem_addr=5 held 3 cycles; if_valid rises cycle after imem_rdy.
REQ-034 id_stall=1 for 4 cycles with if_instr=16'hA5A5 -> if_instr/if_pc unchanged, no imem_req, stall_cnt=4.
REQ-035 if_pc=16'hFFFF, new_pc=16'h0000 -> next imem_addr=16'h0000; call-style new_pc=if_pc+1+20 from pc=5 -> imem_addr=26.
REQ-036 halt=1 with id_stall=1 then released -> halt ignored while stalled; on release halted=1 next cycle, imem_req stays 0 for 10 cycles.
REQ-037 rst_n asserted while in FETCH and in HALTED -> outputs at reset values asynchronously; build without FETCH_PERF_CNT_EN -> counters read 0 throughout.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the PC fetch unit: state encoding, word width, reset PC.
package fetch_pkg;

  localparam int WORD_W = 16;
  localparam logic [WORD_W-1:0] RESET_PC_DEFAULT = 16'h0000;

  typedef enum logic [1:0] {
    FETCH  = 2'd0,
    VALID  = 2'd1,
    HALTED = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: counts enabled cycles, sticks at all-ones, async active-low clear.
module sat_counter
  import fetch_pkg::*;
#(
  parameter int W = WORD_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (en_i && (cnt_q != {W{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/pc_fetch_unit.sv
// Single-outstanding instruction fetch stage: request, hold for decode, stop on halt.
// Performance counters exist only when FETCH_PERF_CNT_EN is defined; otherwise they read 0.
module pc_fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [WORD_W-1:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [WORD_W-1:0] new_pc,
  input  logic              halt,
  input  logic              id_stall,
  input  logic              imem_rdy,
  input  logic [WORD_W-1:0] imem_data,
  output logic              imem_req,
  output logic [WORD_W-1:0] imem_addr,
  output logic              if_valid,
  output logic [WORD_W-1:0] if_instr,
  output logic [WORD_W-1:0] if_pc,
  output logic              halted,
  output logic [WORD_W-1:0] fetch_cnt,
  output logic [WORD_W-1:0] stall_cnt
);

  fetch_state_e      state_q, state_d;
  logic [WORD_W-1:0] pc_q, pc_d;
  logic [WORD_W-1:0] if_instr_q, if_instr_d;
  logic [WORD_W-1:0] if_pc_q, if_pc_d;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    if_instr_d = if_instr_q;
    if_pc_d    = if_pc_q;
    case (state_q)
      FETCH: begin
        if (imem_rdy) begin
          if_instr_d = imem_data;
          if_pc_d    = pc_q;
          state_d    = VALID;
        end
      end
      VALID: begin
        // halt and new_pc only matter once decode takes the instruction
        if (!id_stall) begin
          pc_d    = new_pc;
          state_d = halt ? HALTED : FETCH;
        end
      end
      HALTED: begin
        state_d = HALTED;
      end
      default: begin
        state_d = FETCH;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= FETCH;
      pc_q       <= RESET_PC;
      if_instr_q <= '0;
      if_pc_q    <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      if_instr_q <= if_instr_d;
      if_pc_q    <= if_pc_d;
    end
  end

  assign imem_req  = (state_q == FETCH);
  assign imem_addr = pc_q;
  assign if_valid  = (state_q == VALID);
  assign halted    = (state_q == HALTED);
  assign if_instr  = if_instr_q;
  assign if_pc     = if_pc_q;

`ifdef FETCH_PERF_CNT_EN
  logic fetch_en, stall_en;

  assign fetch_en = (state_q == VALID) && !id_stall;
  assign stall_en = (state_q == VALID) &&  id_stall;

  sat_counter #(.W(WORD_W)) u_fetch_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .en_i  (fetch_en),
    .cnt_o (fetch_cnt)
  );

  sat_counter #(.W(WORD_W)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .en_i  (stall_en),
    .cnt_o (stall_cnt)
  );
`else
  assign fetch_cnt = '0;
  assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit: transaction-level model compared every cycle plus literal anchors.
module tb_pc_fetch_unit;

`ifdef FETCH_PERF_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic [15:0] new_pc;
  logic        halt;
  logic        id_stall;
  logic        imem_rdy;
  logic [15:0] imem_data;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        if_valid;
  logic [15:0] if_instr;
  logic [15:0] if_pc;
  logic        halted;
  logic [15:0] fetch_cnt;
  logic [15:0] stall_cnt;

  logic        np_ovr;
  logic [15:0] np_val;
  logic [15:0] np_off;

  int n_total;
  int n_pass;
  bit done;

  pc_fetch_unit #(.RESET_PC(16'h0000)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .new_pc    (new_pc),
    .halt      (halt),
    .id_stall  (id_stall),
    .imem_rdy  (imem_rdy),
    .imem_data (imem_data),
    .imem_req  (imem_req),
    .imem_addr (imem_addr),
    .if_valid  (if_valid),
    .if_instr  (if_instr),
    .if_pc     (if_pc),
    .halted    (halted),
    .fetch_cnt (fetch_cnt),
    .stall_cnt (stall_cnt)
  );

  function automatic logic [15:0] mem(input logic [15:0] a);
    return (a == 16'd5) ? 16'hA5A5 : (a ^ 16'h1234);
  endfunction

  // Stand-ins for the instruction memory and the external next-PC logic
  assign imem_data = mem(imem_addr);
  assign new_pc    = np_ovr ? np_val : (if_pc + 16'd1 + np_off);

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_total++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: the unit either waits on memory, holds one instruction for decode, or is stopped.
  bit          m_waiting, m_holding, m_stopped;
  logic [15:0] m_pc, m_instr, m_ifpc;
  int          m_fetches, m_stalls;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_waiting = 1'b1; m_holding = 1'b0; m_stopped = 1'b0;
      m_pc = 16'h0000; m_instr = 16'h0000; m_ifpc = 16'h0000;
      m_fetches = 0; m_stalls = 0;
    end else if (m_waiting) begin
      if (imem_rdy) begin
        m_instr = mem(m_pc);
        m_ifpc = m_pc;
        m_waiting = 1'b0;
        m_holding = 1'b1;
      end
    end else if (m_holding) begin
      if (id_stall) begin
        if (m_stalls < 65535) m_stalls++;
      end else begin
        if (m_fetches < 65535) m_fetches++;
        m_pc = new_pc;
        m_holding = 1'b0;
        m_stopped = halt;
        m_waiting = !halt;
      end
    end
  end

  always @(negedge clk) begin
    if (!done) begin
      chk("cyc_imem_req", {15'd0, imem_req}, {15'd0, m_waiting});
      chk("cyc_imem_addr", imem_addr, m_pc);
      chk("cyc_if_valid", {15'd0, if_valid}, {15'd0, m_holding});
      chk("cyc_halted", {15'd0, halted}, {15'd0, m_stopped});
      chk("cyc_if_instr", if_instr, m_instr);
      chk("cyc_if_pc", if_pc, m_ifpc);
      chk("cyc_fetch_cnt", fetch_cnt, CNT_EN ? 16'(m_fetches) : 16'h0000);
      chk("cyc_stall_cnt", stall_cnt, CNT_EN ? 16'(m_stalls) : 16'h0000);
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_req"}, {15'd0, imem_req}, 16'd1);
    chk({tag, "_addr"}, imem_addr, 16'h0000);
    chk({tag, "_valid"}, {15'd0, if_valid}, 16'd0);
    chk({tag, "_halted"}, {15'd0, halted}, 16'd0);
    chk({tag, "_instr"}, if_instr, 16'h0000);
    chk({tag, "_pc"}, if_pc, 16'h0000);
    chk({tag, "_fcnt"}, fetch_cnt, 16'h0000);
    chk({tag, "_scnt"}, stall_cnt, 16'h0000);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_total = 0; n_pass = 0; done = 1'b0;
    rst_n = 1'b0; imem_rdy = 1'b1; id_stall = 1'b0; halt = 1'b0;
    np_ovr = 1'b0; np_val = 16'h0000; np_off = 16'h0000;
    #3;
    chk_reset_vals("rst0");
    @(posedge clk); #2;
    rst_n = 1'b1;

    // Back-to-back fetches 0,1,2 with memory always ready
    step(); chk("seq_v0", {15'd0, if_valid}, 16'd1); chk("seq_pc0", if_pc, 16'h0000);
    chk("seq_i0", if_instr, 16'h1234);
    step(); chk("seq_addr1", imem_addr, 16'h0001); chk("seq_nv1", {15'd0, if_valid}, 16'd0);
    step(); chk("seq_pc1", if_pc, 16'h0001);
    step(); chk("seq_addr2", imem_addr, 16'h0002);
    step(); chk("seq_pc2", if_pc, 16'h0002);
    step(); chk("seq_addr3", imem_addr, 16'h0003);
    if (CNT_EN) chk("seq_fcnt3", fetch_cnt, 16'd3);
    else chk("seq_fcnt_off", fetch_cnt, 16'd0);

    // Memory withholds ready for three edges at pc=5
    step(); step(); step();
    imem_rdy = 1'b0;
    step(); chk("wait_addr_a", imem_addr, 16'h0005); chk("wait_req_a", {15'd0, imem_req}, 16'd1);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("wait_addr", imem_addr, 16'h0005);
      chk("wait_req", {15'd0, imem_req}, 16'd1);
      chk("wait_nv", {15'd0, if_valid}, 16'd0);
    end
    imem_rdy = 1'b1;
    step(); chk("wait_v", {15'd0, if_valid}, 16'd1); chk("wait_pc5", if_pc, 16'h0005);
    chk("wait_i5", if_instr, 16'hA5A5);

    // Decode stalls four cycles
    id_stall = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("stl_instr", if_instr, 16'hA5A5);
      chk("stl_pc", if_pc, 16'h0005);
      chk("stl_req", {15'd0, imem_req}, 16'd0);
    end
    chk("stl_scnt", stall_cnt, CNT_EN ? 16'd4 : 16'd0);

    // Call-style jump: 5 + 1 + 20
    id_stall = 1'b0; np_off = 16'd20;
    step(); np_off = 16'd0;
    chk("call_addr", imem_addr, 16'd26);
    chk("call_fcnt", fetch_cnt, CNT_EN ? 16'd6 : 16'd0);

    // Wrap-around at the top of the address space
    step();
    np_ovr = 1'b1; np_val = 16'hFFFF;
    step(); np_ovr = 1'b0;
    chk("wrap_addr_ffff", imem_addr, 16'hFFFF);
    step(); chk("wrap_pc_ffff", if_pc, 16'hFFFF);
    step(); chk("wrap_addr_0", imem_addr, 16'h0000);

    // Halt ignored while stalled, taken on release
    step(); chk("hlt_v", {15'd0, if_valid}, 16'd1);
    halt = 1'b1; id_stall = 1'b1;
    step(); step();
    chk("hlt_stl_v", {15'd0, if_valid}, 16'd1); chk("hlt_stl_h", {15'd0, halted}, 16'd0);
    id_stall = 1'b0;
    step();
    chk("hlt_h", {15'd0, halted}, 16'd1); chk("hlt_nv", {15'd0, if_valid}, 16'd0);
    halt = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("hlt_req", {15'd0, imem_req}, 16'd0);
      chk("hlt_stay", {15'd0, halted}, 16'd1);
    end

    // Asynchronous reset from HALTED
    #1 rst_n = 1'b0;
    #1 chk_reset_vals("rst_h");
    @(posedge clk); #2;
    rst_n = 1'b1;
    step(); chk("rh_v", {15'd0, if_valid}, 16'd1); chk("rh_pc", if_pc, 16'h0000);
    step(); chk("rh_addr1", imem_addr, 16'h0001);

    // Asynchronous reset with a fetch pending at pc=1
    imem_rdy = 1'b0;
    step();
    #1 rst_n = 1'b0;
    #1 chk_reset_vals("rst_f");
    @(posedge clk); #2;
    rst_n = 1'b1; imem_rdy = 1'b1;
    chk("rf_addr", imem_addr, 16'h0000);
    step(); chk("rf_pc", if_pc, 16'h0000); chk("rf_i", if_instr, 16'h1234);
    step(); step();

    done = 1'b1;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
